// File: rtl/instruction_memory_loader_if.sv
// Load, fetch and status signals between the core and the instruction RAM.
// The master modport is the core/loader side; slave is the RAM block.
interface instruction_memory_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int PC_W   = 32
);
  logic              load_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic [PC_W-1:0]   pc;
  logic              rd_en;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              misaligned;
  logic              out_of_range;
  logic              busy;
  logic [ADDR_W:0]   load_count;

  modport master (
    output load_start, ld_valid, ld_data, ld_last, pc, rd_en,
    input  ld_ready, instr, instr_valid, misaligned, out_of_range, busy, load_count
  );

  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, pc, rd_en,
    output ld_ready, instr, instr_valid, misaligned, out_of_range, busy, load_count
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Run-time loadable instruction RAM. A program is streamed in, the remaining
// words are zeroed, and fetches are then served with a registered 1-cycle read.
module instruction_memory_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int PC_W   = 32
) (
  input  logic clk,
  input  logic rst_n,
  instruction_memory_loader_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              misaligned_q, misaligned_d;
  logic              oor_q, oor_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  logic [ADDR_W-1:0] rd_idx;
  logic              pc_mis, pc_oor;
  logic              wptr_at_end;

  assign rd_idx      = bus.pc[ADDR_W+1:2];
  assign pc_mis      = |bus.pc[1:0];
  assign wptr_at_end = (wptr_q == {ADDR_W{1'b1}});

  // With PC_W == ADDR_W+2 every PC maps onto the array.
  if (PC_W > ADDR_W + 2) begin : g_oor
    assign pc_oor = |bus.pc[PC_W-1:ADDR_W+2];
  end else begin : g_no_oor
    assign pc_oor = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    load_count_d  = load_count_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    misaligned_d  = 1'b0;
    oor_d         = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = bus.ld_data;
    case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          state_d      = S_LOAD;
          wptr_d       = '0;
          load_count_d = '0;
        end
      end
      S_LOAD: begin
        // ld_ready is high for the whole state, so valid alone is a transfer.
        if (bus.ld_valid) begin
          mem_we       = 1'b1;
          wptr_d       = wptr_q + 1'b1;
          load_count_d = load_count_q + (ADDR_W+1)'(1);
          if (wptr_at_end)      state_d = S_RUN;
          else if (bus.ld_last) state_d = S_FILL;
        end
      end
      S_FILL: begin
        mem_we    = 1'b1;
        mem_wdata = '0;
        wptr_d    = wptr_q + 1'b1;
        if (wptr_at_end) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.load_start) begin
          state_d      = S_LOAD;
          wptr_d       = '0;
          load_count_d = '0;
        end else if (bus.rd_en) begin
          instr_valid_d = 1'b1;
          misaligned_d  = pc_mis;
          oor_d         = pc_oor;
          instr_d       = (pc_mis || pc_oor) ? '0 : mem[rd_idx];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wptr_q        <= '0;
      load_count_q  <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      oor_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      load_count_q  <= load_count_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
      oor_q         <= oor_d;
    end
  end

  // Array is deliberately not reset; a completed load defines every word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q] <= mem_wdata;
  end

  assign bus.ld_ready     = (state_q == S_LOAD);
  assign bus.busy         = (state_q == S_LOAD) || (state_q == S_FILL);
  assign bus.instr        = instr_q;
  assign bus.instr_valid  = instr_valid_q;
  assign bus.misaligned   = misaligned_q;
  assign bus.out_of_range = oor_q;
  assign bus.load_count   = load_count_q;
endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: a per-cycle reference model
// plus literal checks on the documented load and fetch scenarios.
module tb_instruction_memory_loader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_memory_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) bus ();

  instruction_memory_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int busy_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 loading, 2 zero-filling, 3 running.
  int          m_mode = 0;
  int          m_cnt  = 0;
  int          m_fill = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_instr = '0;
  logic        m_valid = 1'b0;
  logic        m_mis = 1'b0;
  logic        m_oor = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_cnt <= 0; m_fill <= 0;
      m_instr <= '0; m_valid <= 1'b0; m_mis <= 1'b0; m_oor <= 1'b0;
    end else begin
      m_valid <= 1'b0; m_mis <= 1'b0; m_oor <= 1'b0;
      case (m_mode)
        0: if (bus.load_start) begin m_mode <= 1; m_cnt <= 0; end
        1: if (bus.ld_valid) begin
          m_mem[m_cnt] <= bus.ld_data;
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == DEPTH) m_mode <= 3;
          else if (bus.ld_last) begin
            for (int i = m_cnt + 1; i < DEPTH; i++) m_mem[i] <= '0;
            m_fill <= DEPTH - (m_cnt + 1);
            m_mode <= 2;
          end
        end
        2: begin
          m_fill <= m_fill - 1;
          if (m_fill == 1) m_mode <= 3;
        end
        default: begin
          if (bus.load_start) begin m_mode <= 1; m_cnt <= 0; end
          else if (bus.rd_en) begin
            m_valid <= 1'b1;
            m_mis   <= (bus.pc % 4) != 0;
            m_oor   <= bus.pc >= 4 * DEPTH;
            m_instr <= ((bus.pc % 4) != 0 || bus.pc >= 4 * DEPTH) ? 32'h0
                       : m_mem[(bus.pc / 4) % DEPTH];
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(bus.busy), 64'(m_mode == 1 || m_mode == 2));
    chk("ld_ready", 64'(bus.ld_ready), 64'(m_mode == 1));
    chk("load_count", 64'(bus.load_count), 64'(m_cnt));
    chk("instr_valid", 64'(bus.instr_valid), 64'(m_valid));
    chk("misaligned", 64'(bus.misaligned), 64'(m_mis));
    chk("out_of_range", 64'(bus.out_of_range), 64'(m_oor));
    chk("instr", 64'(bus.instr), 64'(m_instr));
    if (bus.busy) busy_cnt++;
  end

  logic [31:0] ld_words [DEPTH];
  logic [31:0] prog [9] = '{32'h00008020, 32'h20100007, 32'h00008820, 32'h20110001,
                            32'h12000003, 32'h0230881C, 32'h2210FFFF, 32'h08000004,
                            32'hAC110000};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_prog(input int n, input bit last, input bit gap);
    int guard;
    busy_cnt = 0;
    bus.load_start = 1'b1; tick(); bus.load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = ld_words[i]; bus.ld_last = last && (i == n - 1);
      tick();
      bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
      if (gap && i != n - 1) begin
        chk("ld_ready_gap", 64'(bus.ld_ready), 64'd1);
        tick();
      end
    end
    guard = 0;
    while (bus.busy && guard < 1000) begin tick(); guard++; end
    chk("load_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic fetch(input logic [31:0] p);
    bus.pc = p; bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.load_start = 0; bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
    bus.pc = '0; bus.rd_en = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ready", 64'(bus.ld_ready), 64'd0);
    chk("rst_count", 64'(bus.load_count), 64'd0);
    chk("rst_instr", 64'(bus.instr), 64'd0);
    chk("rst_valid", 64'(bus.instr_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // 9-word program with ld_last, contiguous
    for (int i = 0; i < 9; i++) ld_words[i] = prog[i];
    load_prog(9, 1'b1, 1'b0);
    chk("count9", 64'(bus.load_count), 64'd9);
    chk("busy_cycles9", 64'(busy_cnt), 64'd256);
    fetch(32'h20);
    chk("f20_valid", 64'(bus.instr_valid), 64'd1);
    chk("f20_instr", 64'(bus.instr), 64'hAC110000);
    fetch(32'h24);
    chk("f24_instr", 64'(bus.instr), 64'h0);
    tick();
    chk("idle_valid", 64'(bus.instr_valid), 64'd0);

    // Same program with ld_valid toggling
    load_prog(9, 1'b1, 1'b1);
    chk("count9_gap", 64'(bus.load_count), 64'd9);
    for (int i = 0; i < 9; i++) begin
      fetch(32'(4 * i));
      chk("gap_word", 64'(bus.instr), 64'(prog[i]));
    end
    fetch(32'h3FC);
    chk("fill_top", 64'(bus.instr), 64'h0);

    // Back-to-back fetches
    bus.rd_en = 1'b1;
    bus.pc = 32'h0; tick(); chk("pipe0", 64'(bus.instr), 64'h00008020);
    bus.pc = 32'h4; tick(); chk("pipe1", 64'(bus.instr), 64'h20100007);
    bus.pc = 32'h8; tick(); chk("pipe2", 64'(bus.instr), 64'h00008820);
    bus.pc = 32'hC; tick(); chk("pipe3", 64'(bus.instr), 64'h20110001);
    bus.rd_en = 1'b0;

    // Fault flags
    fetch(32'h06);
    chk("mis_instr", 64'(bus.instr), 64'h0);
    chk("mis_flag", 64'({bus.misaligned, bus.out_of_range}), 64'b10);
    fetch(32'h400);
    chk("oor_instr", 64'(bus.instr), 64'h0);
    chk("oor_flag", 64'({bus.misaligned, bus.out_of_range}), 64'b01);
    fetch(32'h402);
    chk("both_instr", 64'(bus.instr), 64'h0);
    chk("both_flag", 64'({bus.misaligned, bus.out_of_range}), 64'b11);

    // Full 256-word load without ld_last
    for (int i = 0; i < DEPTH; i++) ld_words[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    load_prog(DEPTH, 1'b0, 1'b0);
    chk("busy_cycles256", 64'(busy_cnt), 64'd256);
    chk("count256", 64'(bus.load_count), 64'd256);
    bus.ld_valid = 1'b1; bus.ld_data = 32'hDEAD_BEEF;
    #1 chk("ready_257", 64'(bus.ld_ready), 64'd0);
    tick(); bus.ld_valid = 1'b0;
    fetch(32'h3FC);
    chk("w255", 64'(bus.instr), 64'h1000_0000 + 64'd255 * 64'h0001_0003);
    fetch(32'h0);
    chk("w0", 64'(bus.instr), 64'h1000_0000);

    // Reset in the middle of a load
    bus.load_start = 1'b1; tick(); bus.load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = prog[i]; tick();
    end
    bus.ld_valid = 1'b0;
    chk("mid_count", 64'(bus.load_count), 64'd4);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_count", 64'(bus.load_count), 64'd0);
    chk("arst_ready", 64'(bus.ld_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch(32'h0);
    chk("idle_fetch", 64'(bus.instr_valid), 64'd0);

    // load_start beats a simultaneous fetch in RUN
    for (int i = 0; i < 9; i++) ld_words[i] = prog[i];
    load_prog(9, 1'b1, 1'b0);
    bus.load_start = 1'b1; bus.rd_en = 1'b1; bus.pc = 32'h0;
    tick();
    bus.load_start = 1'b0; bus.rd_en = 1'b0;
    chk("ls_rd_valid", 64'(bus.instr_valid), 64'd0);
    chk("ls_rd_busy", 64'(bus.busy), 64'd1);
    chk("ls_rd_count", 64'(bus.load_count), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
- Parametrised successor to the processor's instruction ROM: a word-organised instruction RAM that is filled at run time through a valid/ready load port instead of a fixed initial image.
- Zero-pads every word above the last loaded word, then serves fetches with a registered 1-cycle read and flags misaligned or out-of-range PCs.
- Sits between the PC register and the decoder. The core holds off (stalls) while busy=1.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 8, word-address bits; DEPTH = 2**ADDR_W words.
- PC_W, 32, byte-address (PC) width; must be >= ADDR_W+2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  single-cycle pulse requesting a new program load.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  block accepts a load word this cycle.
- ld_data  in  DATA_W  load word.
- ld_last  in  1  qualifies the final load word.
- pc  in  PC_W  byte fetch address.
- rd_en  in  1  fetch request.
- instr  out  DATA_W  fetched instruction.
- instr_valid  out  1  instr valid this cycle.
- misaligned  out  1  fetch had pc[1:0] != 0.
- out_of_range  out  1  fetch had pc[PC_W-1:ADDR_W+2] != 0.
- busy  out  1  high in LOAD or FILL.
- load_count  out  ADDR_W+1  number of words written by the last completed or ongoing load.

Behaviour:
- States: IDLE, LOAD, FILL, RUN. Reset enters IDLE.
- Reset values: ld_ready=0, instr=0, instr_valid=0, misaligned=0, out_of_range=0, busy=0, load_count=0, write pointer wptr=0.
- Memory array is not reset; its contents are undefined until a load completes.
- IDLE:
  - load_start -> LOAD.
  - rd_en is ignored; instr_valid stays 0.
- LOAD:
  - On entry, wptr and load_count are cleared to 0.
  - ld_ready=1 combinationally whenever state=LOAD.
  - A transfer is ld_valid && ld_ready. Each transfer writes mem[wptr]=ld_data, then wptr+1 and load_count+1.
  - Transfer with ld_last=1 and wptr<DEPTH-1 -> FILL.
  - Transfer at wptr==DEPTH-1 (with or without ld_last) -> RUN, with load_count=DEPTH. Further words are refused because ld_ready drops.
  - Cycles with ld_valid=0 are idle; no timeout.
- FILL:
  - ld_ready=0.
  - Writes mem[wptr]=0 one word per cycle, incrementing wptr.
  - After writing wptr==DEPTH-1 -> RUN. FILL lasts DEPTH-load_count cycles.
  - load_count is not changed by FILL.
- busy=1 exactly in LOAD and FILL.
- RUN:
  - Word index = pc[ADDR_W+1:2].
  - On rd_en=1, the next cycle presents instr and instr_valid=1 (1-cycle latency).
  - Normal fetch: instr = mem[index], both flags 0.
  - Misaligned fetch: instr=0 (NOP), misaligned=1. out_of_range is evaluated independently, so both flags may be 1; instr=0 in that case.
  - Out-of-range fetch: instr=0, out_of_range=1.
  - rd_en=0: instr_valid=0, both flags 0, instr holds its last value.
  - Back-to-back rd_en gives a fully pipelined result every cycle.
- load_start in RUN -> LOAD. If it coincides with rd_en, load_start wins: no fetch result is produced and instr_valid=0 next cycle.
- load_start in LOAD or FILL is ignored.
- ld_valid outside LOAD is ignored and nothing is written.
- rd_en outside RUN: instr_valid=0 next cycle.
- Reset mid-LOAD or mid-FILL: IDLE immediately and all outputs take their reset values. Memory contents become undefined, and a new load is required.

Test Plan:
- Reset, load_start, 9 words 0x00008020, 0x20100007, 0x00008820, 0x20110001, 0x12000003, 0x0230881C, 0x2210FFFF, 0x08000004, 0xAC110000 (ld_last on the 9th) -> load_count=9, busy high for 9+247 cycles, then RUN. Fetch pc=0x20 -> instr=0xAC110000 one cycle later. Fetch pc=0x24 -> 0x00000000.
- Same load with ld_valid toggled every other cycle -> identical contents. ld_ready=1 throughout LOAD and 0 in FILL.
- RUN fetch with rd_en held for pc=0,4,8,12 -> instr 0x00008020, 0x20100007, 0x00008820, 0x20110001 on consecutive cycles, each one cycle after its request.
- Fetch pc=0x06 -> instr=0, misaligned=1. Fetch pc=0x400 -> instr=0, out_of_range=1. Fetch pc=0x402 -> instr=0, both flags 1.
- Load 256 words without ld_last -> RUN directly after the 256th transfer with no FILL, load_count=256. A 257th ld_valid is not accepted (ld_ready=0).
- Assert rst_n=0 after 4 load words -> IDLE the same cycle, load_count=0, busy=0. Fetch in IDLE -> instr_valid stays 0. load_start together with rd_en in RUN -> LOAD entered, instr_valid=0 next cycle.
